tile_spawner: RTL



---
 rtl/tile_spawner.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tile_spawner.sv
// 2048 spawn unit: picks a random empty cell and a 2/4 value using a free-running xorshift32.
// Optional reseed ports are compiled in when TILE_SPAWNER_RESEED_EN is defined.
module tile_spawner #(
  parameter int          POS_W       = 4,
  parameter logic [31:0] SEED        = 32'h392a4953,
  parameter int          MAX_TRIES   = 4,
  parameter int          FOUR_WEIGHT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [(1<<POS_W)-1:0]   empty_mask,
`ifdef TILE_SPAWNER_RESEED_EN
  input  logic                    seed_load,
  input  logic [31:0]             seed_val,
`endif
  output logic                    busy,
  output logic                    done,
  output logic                    full,
  output logic [POS_W-1:0]        pos,
  output logic                    is_four
);

  localparam int          N_CELLS   = 1 << POS_W;
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;
  localparam logic [3:0]  LAST_TRY  = 4'(MAX_TRIES - 1);
  localparam logic [4:0]  FOUR_LIM  = 5'(FOUR_WEIGHT);

  typedef enum logic [1:0] {IDLE, DRAW, SCAN, FIN} state_t;

  state_t             state, state_d;
  logic [31:0]        rng, rng_step;
  logic [N_CELLS-1:0] mask_q, mask_d;
  logic [3:0]         tries, tries_d;
  logic [POS_W-1:0]   scan_idx, scan_d;
  logic [POS_W-1:0]   pos_d, idx;
  logic               is_four_d, full_q, full_d, four_draw;

  function automatic logic [31:0] xorshift(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  always_comb rng_step = xorshift(rng);

  // The generator never pauses, so the draw depends on when start arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      rng <= SEED_INIT;
`ifdef TILE_SPAWNER_RESEED_EN
    end else if (seed_load) begin
      rng <= (seed_val == 32'd0) ? 32'd1 : seed_val;
`endif
    end else begin
      rng <= rng_step;
    end
  end

  assign idx       = rng[POS_W-1:0];
  assign four_draw = {1'b0, rng[31:28]} < FOUR_LIM;

  always_comb begin
    state_d   = state;
    mask_d    = mask_q;
    tries_d   = tries;
    scan_d    = scan_idx;
    pos_d     = pos;
    is_four_d = is_four;
    full_d    = full_q;
    unique case (state)
      IDLE: begin
        if (start) begin
          mask_d  = empty_mask;
          tries_d = 4'd0;
          if (empty_mask == '0) begin
            full_d  = 1'b1;
            state_d = FIN;
          end else begin
            state_d = DRAW;
          end
        end
      end
      DRAW: begin
        if (mask_q[idx]) begin
          pos_d     = idx;
          is_four_d = four_draw;
          state_d   = FIN;
        end else if (tries == LAST_TRY) begin
          scan_d  = idx + 1'b1;
          state_d = SCAN;
        end else begin
          tries_d = tries + 4'd1;
        end
      end
      SCAN: begin
        // mask_q is non-zero here, so the walk always terminates.
        if (mask_q[scan_idx]) begin
          pos_d     = scan_idx;
          is_four_d = four_draw;
          state_d   = FIN;
        end else begin
          scan_d = scan_idx + 1'b1;
        end
      end
      FIN: begin
        full_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      mask_q   <= '0;
      tries    <= 4'd0;
      scan_idx <= '0;
      pos      <= '0;
      is_four  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state    <= state_d;
      mask_q   <= mask_d;
      tries    <= tries_d;
      scan_idx <= scan_d;
      pos      <= pos_d;
      is_four  <= is_four_d;
      full_q   <= full_d;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign full = full_q;

endmodule
